wiphase_ocimem_arbiter: RTL and testbench

//  Shares one single-port debug RAM (OCI memory, 32-bit words) between two requesters:
//   - JTAG debug-slave command strobes, take_action_ocimem_a/b with jdo.
//   - The CPU-side Avalon debug slave.

---
 rtl/wiphase_dbg_pkg.sv | 20 ++
 rtl/wiphase_dbg_rr_arb2.sv | 35 +++
 rtl/wiphase_ocimem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_wiphase_ocimem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wiphase_dbg_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory arbiter.
// Contents: FSM state enum, requester enum, jdo bit-field localparams.
package wiphase_dbg_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RD_CAP = 1'b1
    } fsm_state_t;

    typedef enum logic {
        REQ_AV   = 1'b0,
        REQ_JTAG = 1'b1
    } req_t;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RD_BIT    = 35;
    localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/wiphase_dbg_rr_arb2.sv
// Two-way round-robin arbiter between the Avalon slave and the JTAG slot.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   req_av, req_jtag    requests (already qualified by the caller)
//   gnt_av, gnt_jtag    one-hot combinational grants
// On contention the requester that did not win last time is granted.
module wiphase_dbg_rr_arb2
    import wiphase_dbg_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_av,
    input  logic req_jtag,
    output logic gnt_av,
    output logic gnt_jtag
);

    req_t last_grant;

    always_comb begin
        gnt_jtag = req_jtag && (!req_av || (last_grant == REQ_AV));
        gnt_av   = req_av && !gnt_jtag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_AV;
        end else if (gnt_jtag) begin
            last_grant <= REQ_JTAG;
        end else if (gnt_av) begin
            last_grant <= REQ_AV;
        end
    end

endmodule

// File: rtl/wiphase_ocimem_arbiter.sv
// Shares a single-port OCI debug RAM between the JTAG debug slave and the
// CPU-side Avalon debug slave. JTAG strobes are held in a one-deep slot,
// the two sides are arbitrated round-robin, and reads are sequenced
// through a capture state that registers the RAM's 1-cycle read data.
// Ports:
//   clk, reset                      system clock, synchronous active-high reset
//   jdo, take_action_ocimem_a/b,    JTAG command word and strobes
//   take_no_action_ocimem_a
//   av_*                            Avalon debug slave
//   ram_addr/ram_we/ram_wdata/      single-port RAM, registered read data
//   ram_rdata
//   mon_dreg, mon_ready             JTAG read-back data and landed flag
//   jtag_ovf                        sticky: a JTAG strobe was dropped
// Build option: WIPHASE_OCIMEM_AUTOINC_EN advances the JTAG address on
// every granted JTAG op, for burst dumps/loads.
//
// state  | meaning
// IDLE   | grants a requester combinationally; writes stay here
// RD_CAP | RAM read in flight; registers ram_rdata to the read's owner
module wiphase_ocimem_arbiter
    import wiphase_dbg_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    output logic              av_waitrequest,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_readdatavalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] mon_dreg,
    output logic              mon_ready,
    output logic              jtag_ovf
);

    fsm_state_t        state;
    req_t              rd_owner;
    logic              pending;
    logic              pend_rd;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;
    logic [ADDR_W-1:0] jtag_addr;
    logic [ADDR_W-1:0] jtag_addr_eff;
    logic [ADDR_W-1:0] jdo_addr;
    logic              req_av;
    logic              req_jtag;
    logic              gnt_av;
    logic              gnt_jtag;
    logic              slot_free;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

    // Grants are suppressed while reset is held so the RAM port and
    // waitrequest show their reset values in that cycle.
    assign req_av   = (av_read || av_write) && (state == IDLE) && !reset;
    assign req_jtag = pending && (state == IDLE) && !reset;

    wiphase_dbg_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_av   (req_av),
        .req_jtag (req_jtag),
        .gnt_av   (gnt_av),
        .gnt_jtag (gnt_jtag)
    );

    assign av_waitrequest = (av_read || av_write) && !gnt_av;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (gnt_jtag) begin
            ram_addr  = pend_addr;
            ram_we    = !pend_rd;
            ram_wdata = pend_wdata;
        end else if (gnt_av) begin
            ram_addr  = av_address;
            ram_we    = av_write;
            ram_wdata = av_writedata;
        end
    end

    assign jdo_addr = jdo[JDO_ADDR_LSB +: ADDR_W];

    // A strobe landing in the grant cycle refills the slot it just vacated.
    assign slot_free = !pending || gnt_jtag;

    // Address a write strobe would use this cycle, accounting for an
    // increment from a JTAG grant happening at the same time.
    always_comb begin
`ifdef WIPHASE_OCIMEM_AUTOINC_EN
        jtag_addr_eff = gnt_jtag ? jtag_addr + ADDR_W'(1) : jtag_addr;
`else
        jtag_addr_eff = jtag_addr;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= 1'b0;
            pend_rd    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            jtag_addr  <= '0;
            jtag_ovf   <= 1'b0;
        end else begin
            if (gnt_jtag) begin
                pending <= 1'b0;
            end
`ifdef WIPHASE_OCIMEM_AUTOINC_EN
            if (gnt_jtag) begin
                jtag_addr <= jtag_addr + ADDR_W'(1);
            end
`endif
            // Clear first so a drop in the same cycle keeps the flag set.
            if (take_no_action_ocimem_a) begin
                jtag_ovf <= 1'b0;
            end
            if (take_action_ocimem_a) begin
                if (slot_free) begin
                    jtag_addr <= jdo_addr;
                    if (jdo[JDO_RD_BIT]) begin
                        pending   <= 1'b1;
                        pend_rd   <= 1'b1;
                        pend_addr <= jdo_addr;
                    end
                end else begin
                    jtag_ovf <= 1'b1;
                end
                if (take_action_ocimem_b) begin
                    jtag_ovf <= 1'b1;
                end
            end else if (take_action_ocimem_b) begin
                if (slot_free) begin
                    pending    <= 1'b1;
                    pend_rd    <= 1'b0;
                    pend_addr  <= jtag_addr_eff;
                    pend_wdata <= jdo[JDO_WDATA_LSB +: DATA_W];
                end else begin
                    jtag_ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            rd_owner         <= REQ_AV;
            av_readdata      <= '0;
            av_readdatavalid <= 1'b0;
            mon_dreg         <= '0;
            mon_ready        <= 1'b0;
        end else begin
            av_readdatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_av && av_read) begin
                        state    <= RD_CAP;
                        rd_owner <= REQ_AV;
                    end else if (gnt_jtag && pend_rd) begin
                        state    <= RD_CAP;
                        rd_owner <= REQ_JTAG;
                    end
                end
                RD_CAP: begin
                    if (rd_owner == REQ_AV) begin
                        av_readdata      <= ram_rdata;
                        av_readdatavalid <= 1'b1;
                    end else begin
                        mon_dreg  <= ram_rdata;
                        mon_ready <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A new JTAG command invalidates the previous read-back.
            if (take_action_ocimem_a || take_action_ocimem_b) begin
                mon_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wiphase_ocimem_arbiter.sv
module tb_wiphase_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_b, take_na;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mon_dreg;
    logic        mon_ready;
    logic        jtag_ovf;

    wiphase_ocimem_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_waitrequest          (av_waitrequest),
        .av_readdata             (av_readdata),
        .av_readdatavalid        (av_readdatavalid),
        .ram_addr                (ram_addr),
        .ram_we                  (ram_we),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .mon_dreg                (mon_dreg),
        .mon_ready               (mon_ready),
        .jtag_ovf                (jtag_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read data.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_av[$];
    logic [31:0] exp_mon[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_we  = 0;
    int n_rdv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents a
    // RAM write, an Avalon read beat, or freshly landed JTAG read data.
    logic mon_ready_q = 1'b0;
    wr_t  e;
    always @(negedge clk) begin
        if (ram_we) begin
            n_we++;
            if (exp_wr.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_ram_write: got addr %h data %h expected none", ram_addr, ram_wdata);
            end else begin
                e = exp_wr.pop_front();
                check("ram_wr_addr", 32'(ram_addr), 32'(e.addr));
                check("ram_wr_data", ram_wdata, e.data);
            end
        end
        if (av_readdatavalid) begin
            n_rdv++;
            if (exp_av.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_av_rdv: got data %h expected none", av_readdata);
            end else begin
                check("av_readdata", av_readdata, exp_av.pop_front());
            end
        end
        if (mon_ready && !mon_ready_q) begin
            if (exp_mon.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_mon_ready: got data %h expected none", mon_dreg);
            end else begin
                check("mon_dreg", mon_dreg, exp_mon.pop_front());
            end
        end
        mon_ready_q = mon_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic [7:0] addr, input logic rd);
        logic [37:0] w;
        w = '0;
        w[24:17] = addr;
        w[35] = rd;
        jdo = w;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] data);
        logic [37:0] w;
        w = '0;
        w[34:3] = data;
        jdo = w;
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
    endtask

    task automatic av_wr(input logic [7:0] addr, input logic [31:0] data);
        exp_wr.push_back('{addr: addr, data: data});
        av_write = 1'b1;
        av_address = addr;
        av_writedata = data;
        #1;
        check("av_wr_waitrequest", 32'(av_waitrequest), 32'd0);
        @(posedge clk);
        #1;
        av_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] wrap_addr;
    int we0, rdv0;

    initial begin
        reset = 1'b1;
        jdo = '0; take_a = 0; take_b = 0; take_na = 0;
        av_address = '0; av_read = 0; av_write = 0; av_writedata = '0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_waitrequest", 32'(av_waitrequest), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_mon_ready", 32'(mon_ready), 32'd0);
        check("rst_jtag_ovf", 32'(jtag_ovf), 32'd0);
        check("rst_av_rdv", 32'(av_readdatavalid), 32'd0);

        // 1: JTAG write then read back
        exp_wr.push_back('{addr: 8'h10, data: 32'hDEADBEEF});
        strobe_a(8'h10, 1'b0);
        strobe_b(32'hDEADBEEF);
        check("t1_wr_we", 32'(ram_we), 32'd1);
        check("t1_wr_addr", 32'(ram_addr), 32'h10);
        tick();
        exp_mon.push_back(32'hDEADBEEF);
        strobe_a(8'h10, 1'b1);
        check("t1_rd_addr", 32'(ram_addr), 32'h10);
        check("t1_rd_we", 32'(ram_we), 32'd0);
        tick();
        check("t1_mon_ready_t1", 32'(mon_ready), 32'd0);
        tick();
        check("t1_mon_ready_t2", 32'(mon_ready), 32'd1);
        check("t1_mon_dreg_t2", mon_dreg, 32'hDEADBEEF);
        tick();

        // 2: contention with last_grant = AV
        av_wr(8'h20, 32'h12345678);
        strobe_a(8'h30, 1'b0);
        rdv0 = n_rdv;
        exp_wr.push_back('{addr: 8'h30, data: 32'hCAFEF00D});
        exp_av.push_back(32'h12345678);
        jdo = {3'b000, 32'hCAFEF00D, 3'b000};
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        av_read = 1'b1;
        av_address = 8'h20;
        #1;
        check("t2_jtag_first_we", 32'(ram_we), 32'd1);
        check("t2_jtag_first_addr", 32'(ram_addr), 32'h30);
        check("t2_av_waits", 32'(av_waitrequest), 32'd1);
        tick();
        check("t2_av_next_wait", 32'(av_waitrequest), 32'd0);
        check("t2_av_next_addr", 32'(ram_addr), 32'h20);
        check("t2_av_next_we", 32'(ram_we), 32'd0);
        tick();
        av_read = 1'b0;
        check("t2_rdv_t1", 32'(av_readdatavalid), 32'd0);
        tick();
        check("t2_rdv_t2", 32'(av_readdatavalid), 32'd1);
        tick();
        tick();
        check("t2_rdv_once", 32'(n_rdv - rdv0), 32'd1);

        // 3: overflow while Avalon read holds RD_CAP
        strobe_a(8'h40, 1'b0);
        exp_av.push_back(32'hDEADBEEF);
        exp_wr.push_back('{addr: 8'h40, data: 32'h11111111});
        av_read = 1'b1;
        av_address = 8'h10;
        jdo = {3'b000, 32'h11111111, 3'b000};
        take_b = 1'b1;
        #1;
        check("t3_av_grant", 32'(av_waitrequest), 32'd0);
        tick();
        av_read = 1'b0;
        jdo = {3'b000, 32'h22222222, 3'b000};
        #1;
        check("t3_rdcap_no_we", 32'(ram_we), 32'd0);
        tick();
        take_b = 1'b0;
        check("t3_ovf_set", 32'(jtag_ovf), 32'd1);
        check("t3_first_wdata", ram_wdata, 32'h11111111);
        check("t3_av_rdv", 32'(av_readdatavalid), 32'd1);
        tick();
        tick();
        check("t3_ovf_sticky", 32'(jtag_ovf), 32'd1);
        take_na = 1'b1;
        tick();
        take_na = 1'b0;
        check("t3_ovf_cleared", 32'(jtag_ovf), 32'd0);

        // 4: address wrap; second strobe lands in the grant cycle
`ifdef WIPHASE_OCIMEM_AUTOINC_EN
        wrap_addr = 8'h00;
`else
        wrap_addr = 8'hFF;
`endif
        exp_wr.push_back('{addr: 8'hFF, data: 32'hA1A1A1A1});
        exp_wr.push_back('{addr: wrap_addr, data: 32'hA2A2A2A2});
        strobe_a(8'hFF, 1'b0);
        strobe_b(32'hA1A1A1A1);
        check("t4_first_addr", 32'(ram_addr), 32'hFF);
        strobe_b(32'hA2A2A2A2);
        check("t4_second_we", 32'(ram_we), 32'd1);
        check("t4_second_addr", 32'(ram_addr), 32'(wrap_addr));
        check("t4_no_ovf", 32'(jtag_ovf), 32'd0);
        tick();

        // 5: reset while in RD_CAP
        av_read = 1'b1;
        av_address = 8'h50;
        #1;
        check("t5_av_grant", 32'(av_waitrequest), 32'd0);
        tick();
        av_read = 1'b0;
        reset = 1'b1;
        tick();
        check("t5_no_rdv", 32'(av_readdatavalid), 32'd0);
        check("t5_readdata", av_readdata, 32'd0);
        check("t5_mon_dreg", mon_dreg, 32'd0);
        check("t5_mon_ready", 32'(mon_ready), 32'd0);
        check("t5_ovf", 32'(jtag_ovf), 32'd0);
        check("t5_ram_we", 32'(ram_we), 32'd0);
        av_read = 1'b1;
        #1;
        check("t5_wait_in_reset", 32'(av_waitrequest), 32'd1);
        check("t5_ram_addr_in_reset", 32'(ram_addr), 32'd0);
        av_read = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("t5_no_rdv_after", 32'(av_readdatavalid), 32'd0);

        // 6: back-to-back Avalon writes
        we0 = n_we;
        for (int i = 0; i < 8; i++) begin
            av_wr(8'(i), 32'h0000_0600 + 32'(i));
        end
        tick();
        check("t6_we_count", 32'(n_we - we0), 32'd8);

        tick();
        check("left_exp_wr", 32'(exp_wr.size()), 32'd0);
        check("left_exp_av", 32'(exp_av.size()), 32'd0);
        check("left_exp_mon", 32'(exp_mon.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
